// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM-style memory port between NUM_REQ
// requesters. Grant and memory drive are combinational. A latency pipeline
// routes each response pulse back to the requester that issued the access.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       addr_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       wdata_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]             mem_be_o,
    output logic [DATA_WIDTH-1:0]               mem_data_o,
    input  logic [DATA_WIDTH-1:0]               mem_data_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_d;
    logic [NUM_REQ-1:0]     req_act;
    logic                   any_req;
    logic                   found;
    logic [31:0]            cand;
    logic [IDX_W-1:0]       winner;
    logic [MEM_LATENCY-1:0] pipe_vld_q;
    logic [IDX_W-1:0]       pipe_idx_q [MEM_LATENCY];

    // Requests are masked while reset is held so every output reads zero.
    always_comb begin
        req_act = rst_ni ? req_i : '0;
        any_req = |req_act;
    end

    // Round-robin search starting at ptr_q and wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && req_act[IDX_W'(cand)]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    // One-hot grant and next priority pointer (one past the winner).
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (any_req) begin
            gnt_o = NUM_REQ'(1) << winner;
            ptr_d = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
        end
    end

    // Memory port driven from the winner's slices; all zero when idle.
    always_comb begin
        mem_req_o  = any_req;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_be_o   = '0;
        mem_data_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (any_req && (winner == IDX_W'(i))) begin
                mem_we_o   = we_i[i];
                mem_addr_o = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_be_o   = be_i[i*BE_W +: BE_W];
                mem_data_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Response pipeline: stage 0 captures {grant, winner} every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            for (int unsigned s = 0; s < MEM_LATENCY; s++) begin
                pipe_idx_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= any_req;
            pipe_idx_q[0] <= winner;
            for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
        end
    end

    // Response pulse to the issuing requester; read data passes straight through.
    always_comb begin
        rvalid_o = '0;
        if (pipe_vld_q[MEM_LATENCY-1]) begin
            rvalid_o = NUM_REQ'(1) << pipe_idx_q[MEM_LATENCY-1];
        end
        rdata_o = rst_ni ? mem_data_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (2 req/lat 1, 2 req/lat 2,
// 3 req/lat 3) share stimulus; a grant-history model checks every cycle.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0]      req, we;
    logic [3*AW-1:0] addr;
    logic [3*BW-1:0] be;
    logic [3*DW-1:0] wdata;
    logic [DW-1:0]   mem_rd;

    logic [1:0] ga, rva, gb, rvb;
    logic [2:0] gc, rvc;
    logic [DW-1:0] rda, rdb, rdc, mda, mdb, mdc;
    logic mra, mwa, mrb, mwb, mrc, mwc;
    logic [AW-1:0] maa, mab, mac;
    logic [BW-1:0] mba, mbb, mbc;

    int n_checks = 0;
    int n_pass   = 0;
    int nreq [3] = '{2, 2, 3};
    int lat  [3] = '{1, 2, 3};
    int ptr_m[3];
    int hist [3][4];
    logic [2:0] last_g;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .we_i(we[1:0]),
        .addr_i(addr[2*AW-1:0]), .be_i(be[2*BW-1:0]), .wdata_i(wdata[2*DW-1:0]),
        .gnt_o(ga), .rvalid_o(rva), .rdata_o(rda), .mem_req_o(mra), .mem_we_o(mwa),
        .mem_addr_o(maa), .mem_be_o(mba), .mem_data_o(mda), .mem_data_i(mem_rd));

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .we_i(we[1:0]),
        .addr_i(addr[2*AW-1:0]), .be_i(be[2*BW-1:0]), .wdata_i(wdata[2*DW-1:0]),
        .gnt_o(gb), .rvalid_o(rvb), .rdata_o(rdb), .mem_req_o(mrb), .mem_we_o(mwb),
        .mem_addr_o(mab), .mem_be_o(mbb), .mem_data_o(mdb), .mem_data_i(mem_rd));

    mem_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
        .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gc), .rvalid_o(rvc), .rdata_o(rdc), .mem_req_o(mrc), .mem_we_o(mwc),
        .mem_addr_o(mac), .mem_be_o(mbc), .mem_data_o(mdc), .mem_data_i(mem_rd));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        else n_pass++;
    endtask

    // First requesting index at or after p, wrapping over n requesters.
    function automatic int win(input logic [2:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_check(input int k, input logic [2:0] g, input logic [2:0] rv,
                               input logic [DW-1:0] rd, input logic mr, input logic mw,
                               input logic [AW-1:0] ma, input logic [BW-1:0] mb,
                               input logic [DW-1:0] md);
        int n, w, h;
        logic [2:0] msk, eg, erv;
        logic ew;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed, erd;
        n = nreq[k];
        msk = (n == 3) ? 3'b111 : 3'b011;
        eg = '0; erv = '0; ew = 1'b0; ea = '0; eb = '0; ed = '0; erd = '0; w = -1;
        if (rst_n) begin
            w = win(req & msk, ptr_m[k], n);
            h = hist[k][lat[k]-1];
            if (w >= 0) begin
                eg = 3'b001 << w;
                ew = we[w];
                ea = addr[w*AW +: AW];
                eb = be[w*BW +: BW];
                ed = wdata[w*DW +: DW];
            end
            if (h >= 0) erv = 3'b001 << h;
            erd = mem_rd;
        end
        chk($sformatf("u%0d_gnt", k), 64'(g), 64'(eg));
        chk($sformatf("u%0d_rvalid", k), 64'(rv), 64'(erv));
        chk($sformatf("u%0d_rdata", k), 64'(rd), 64'(erd));
        chk($sformatf("u%0d_mem_req", k), 64'(mr), 64'(w >= 0));
        chk($sformatf("u%0d_mem_we", k), 64'(mw), 64'(ew));
        chk($sformatf("u%0d_mem_addr", k), ma, ea);
        chk($sformatf("u%0d_mem_be", k), 64'(mb), 64'(eb));
        chk($sformatf("u%0d_mem_data", k), 64'(md), 64'(ed));
        if (rst_n) begin
            for (int s = 3; s > 0; s--) hist[k][s] = hist[k][s-1];
            hist[k][0] = w;
            if (w >= 0) ptr_m[k] = (w + 1) % n;
        end else begin
            ptr_m[k] = 0;
            for (int s = 0; s < 4; s++) hist[k][s] = -1;
        end
    endtask

    // Per-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        model_check(0, {1'b0, ga}, {1'b0, rva}, rda, mra, mwa, maa, mba, mda);
        model_check(1, {1'b0, gb}, {1'b0, rvb}, rdb, mrb, mwb, mab, mbb, mdb);
        model_check(2, gc, rvc, rdc, mrc, mwc, mac, mbc, mdc);
        last_g = {gc[2], ga};
    end

    initial begin
        rst_n = 1'b0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        mem_rd = 32'hDEADBEEF; last_g = '0;
        for (int k = 0; k < 3; k++) begin
            ptr_m[k] = 0;
            for (int s = 0; s < 4; s++) hist[k][s] = -1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read
        @(posedge clk); #1; req = 3'b001; we = '0; addr[63:0] = 64'h100;
        @(negedge clk);
        chk("t1_gnt", 64'(ga), 64'h1);
        chk("t1_mem_req", 64'(mra), 64'h1);
        chk("t1_mem_addr", maa, 64'h100);
        chk("t1_rvalid_early", 64'(rva), 64'h0);
        @(posedge clk); #1; req = '0;
        @(negedge clk);
        chk("t1_rvalid", 64'(rva), 64'h1);
        chk("t1_rdata", 64'(rda), 64'hDEADBEEF);

        // Contention from reset
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; req = 3'b011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i == 4) req = '0;
            @(negedge clk);
            if (i < 4) chk("t2_gnt", 64'(ga), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) chk("t2_rvalid", 64'(rva), ((i - 1) % 2 == 0) ? 64'h1 : 64'h2);
        end

        // Write with byte enables from requester 1
        @(posedge clk); #1;
        req = 3'b010; we = 3'b010; addr[127:64] = 64'h40; be[7:4] = 4'h6; wdata[63:32] = 32'hAABBCCDD;
        @(negedge clk);
        chk("t3_gnt", 64'(ga), 64'h2);
        chk("t3_mem_we", 64'(mwa), 64'h1);
        chk("t3_mem_be", 64'(mba), 64'h6);
        chk("t3_mem_data", 64'(mda), 64'hAABBCCDD);
        chk("t3_mem_addr", maa, 64'h40);
        @(posedge clk); #1; req = '0; we = '0;
        @(negedge clk);
        chk("t3_rvalid", 64'(rva), 64'h2);

        // Latency-3 sweep, alternating requesters back to back
        repeat (4) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req = (i < 5) ? ((i % 2 == 0) ? 3'b001 : 3'b010) : 3'b000;
            addr[63:0] = 64'(i * 16); addr[127:64] = 64'(i * 16 + 8);
            @(negedge clk);
            if (i < 5) chk("t4_gnt", 64'(gc), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i >= 3) chk("t4_rvalid", 64'(rvc), ((i - 3) % 2 == 0) ? 64'h1 : 64'h2);
            else chk("t4_rvalid_idle", 64'(rvc), 64'h0);
        end

        // Reset while a latency-2 response is in flight
        @(posedge clk); #1; req = 3'b010;
        @(negedge clk);
        chk("t5_gnt", 64'(gb), 64'h2);
        @(posedge clk); #1; req = '0; rst_n = 1'b0;
        #1;
        chk("t5_rst_rvalid", 64'(rvb), 64'h0);
        chk("t5_rst_gnt", 64'(gb), 64'h0);
        chk("t5_rst_mem_req", 64'(mrb), 64'h0);
        chk("t5_rst_rdata", 64'(rdb), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_rvalid", 64'(rvb), 64'h0);
            @(posedge clk); #1;
        end
        req = 3'b011;
        @(negedge clk);
        chk("t5_post_gnt", 64'(gb), 64'h1);

        // Idle cycles hold the pointer and zero the memory port
        @(posedge clk); #1; req = 3'b001;
        @(negedge clk);
        chk("t6_gnt0", 64'(ga), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req = '0; we = 3'b111; addr = {3{64'h1234}}; be = '1; wdata = {3{32'h5555AAAA}};
            @(negedge clk);
            chk("t6_idle_mem_req", 64'(mra), 64'h0);
            chk("t6_idle_mem_we", 64'(mwa), 64'h0);
            chk("t6_idle_mem_addr", maa, 64'h0);
            chk("t6_idle_mem_be", 64'(mba), 64'h0);
            chk("t6_idle_mem_data", 64'(mda), 64'h0);
        end
        @(posedge clk); #1; req = 3'b011; we = '0;
        @(negedge clk);
        chk("t6_gnt_after_idle", 64'(ga), 64'h2);

        // Randomized traffic; a pending requester keeps its payload until granted
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst_n  = ($urandom_range(0, 199) != 0);
            mem_rd = $urandom();
            for (int i = 0; i < 3; i++) begin
                if (!(req[i] && !last_g[i]) || !rst_n) begin
                    req[i] = ($urandom_range(0, 9) < 7);
                    we[i]  = $urandom_range(0, 1) != 0;
                    addr[i*AW +: AW]  = {$urandom(), $urandom()};
                    be[i*BW +: BW]    = BW'($urandom_range(0, 15));
                    wdata[i*DW +: DW] = $urandom();
                end
            end
        end
        @(posedge clk); #1; req = '0;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
